// File: rtl/pe_dot_acc.sv
// pe_dot_acc: pipelined LANES-wide signed dot product with multi-beat accumulation.
// Define PE_DOT_ACC_SAT_EN to clamp the accumulator instead of wrapping it.
module pe_dot_acc #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int ACCW  = 48,
  parameter int CNTW  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_first_i,
  input  logic                  in_last_i,
  input  logic [LANES*DW-1:0]   neuron_i,
  input  logic [LANES*DW-1:0]   weight_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ACCW-1:0]       out_data_o,
  output logic [CNTW-1:0]       out_beats_o,
  output logic                  out_sat_o
);
  localparam int LSW = 2*DW + $clog2(LANES);
  localparam int SW  = (ACCW > LSW ? ACCW : LSW) + 1;

  logic                   en;
  logic signed [2*DW-1:0] prod_d [LANES];
  logic signed [2*DW-1:0] s1_prod_q [LANES];
  logic                   s1_v_q, s1_first_q, s1_last_q;
  logic signed [LSW-1:0]  sum_d, s2_sum_q;
  logic                   s2_v_q, s2_first_q, s2_last_q;
  logic signed [ACCW-1:0] psum_q, res;
  logic signed [SW-1:0]   wide;
  logic                   last_q, start, ov, sat_d, sat_q, out_valid_d, out_valid_q, out_sat_q;
  logic [CNTW-1:0]        cnt_d, cnt_q, out_beats_q;
  logic [ACCW-1:0]        out_data_q;

  assign en          = !(out_valid_q && !out_ready_i);
  assign in_ready_o  = en;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_beats_o = out_beats_q;
  assign out_sat_o   = out_sat_q;

  always_comb begin
    for (int i = 0; i < LANES; i++)
      prod_d[i] = $signed(neuron_i[i*DW +: DW]) * $signed(weight_i[i*DW +: DW]);
    sum_d = '0;
    for (int i = 0; i < LANES; i++)
      sum_d = sum_d + LSW'(s1_prod_q[i]);
  end

  // last_q resets high so the first beat after reset always starts a fresh vector
  assign start = s2_first_q || last_q;
  assign wide  = (start ? SW'(0) : SW'(psum_q)) + SW'(s2_sum_q);

`ifdef PE_DOT_ACC_SAT_EN
  assign ov  = !((&wide[SW-1:ACCW-1]) || !(|wide[SW-1:ACCW-1]));
  assign res = ov ? {wide[SW-1], {(ACCW-1){~wide[SW-1]}}} : wide[ACCW-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^wide[SW-1:ACCW];
  assign ov  = 1'b0;
  assign res = wide[ACCW-1:0];
`endif

  assign cnt_d       = start ? CNTW'(1) : cnt_q + CNTW'(!(&cnt_q));
  assign sat_d       = start ? ov : (sat_q || ov);
  assign out_valid_d = (out_valid_q && !out_ready_i) || (en && s2_v_q && s2_last_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_prod_q   <= '{default: '0};
      s1_v_q      <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_v_q      <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      psum_q      <= '0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (en) begin
        s1_prod_q  <= prod_d;
        s1_v_q     <= in_valid_i;
        s1_first_q <= in_first_i;
        s1_last_q  <= in_last_i;
        s2_sum_q   <= sum_d;
        s2_v_q     <= s1_v_q;
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        if (s2_v_q) begin
          psum_q <= res;
          last_q <= s2_last_q;
          cnt_q  <= cnt_d;
          sat_q  <= sat_d;
          if (s2_last_q) begin
            out_data_q  <= res;
            out_beats_q <= cnt_d;
            out_sat_q   <= sat_d;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_dot_acc.sv
// tb_pe_dot_acc: directed vectors for pe_dot_acc (48-bit main instance, 32-bit overflow instance).
module tb_pe_dot_acc;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1, v32 = 1'b0;
  logic [511:0] neuron = '0, weight = '0;
  logic         in_ready, out_valid, out_sat, rdy32, ov32, sat32;
  logic [47:0]  out_data;
  logic [31:0]  data32;
  logic [15:0]  out_beats, beats32;
  int           vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  pe_dot_acc dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_first_i(in_first), .in_last_i(in_last), .neuron_i(neuron), .weight_i(weight),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_beats_o(out_beats), .out_sat_o(out_sat)
  );

  pe_dot_acc #(.ACCW(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v32), .in_ready_o(rdy32),
    .in_first_i(in_first), .in_last_i(in_last), .neuron_i(neuron), .weight_i(weight),
    .out_valid_o(ov32), .out_ready_i(1'b1), .out_data_o(data32),
    .out_beats_o(beats32), .out_sat_o(sat32)
  );

  typedef struct {
    string        name;
    logic [511:0] n, w;
    longint       exp;
  } vec_t;

  function automatic logic [511:0] rep(input logic [15:0] v);
    return {32{v}};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the beat was accepted
  task automatic beat(input logic [511:0] n, w, input logic f, l);
    int g;
    neuron = n; weight = w; in_first = f; in_last = l; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g == 50) chk("beat_accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, input longint exp, input longint bts, input longint sat);
    int g;
    g = 0;
    while (!out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 0, 1);
    else begin
      chk({nm, "_data"}, $signed(out_data), exp);
      chk({nm, "_beats"}, longint'(out_beats), bts);
      chk({nm, "_sat"}, longint'(out_sat), sat);
    end
    @(negedge clk);
  endtask

  vec_t tbl[5];
  logic [511:0] big;
  int seen;

  initial begin
    tbl[0] = '{"lane0_neg", 512'(16'hFFFD), 512'(16'd7), -21};
    tbl[1] = '{"all_1x1", rep(16'd1), rep(16'd1), 32};
    tbl[2] = '{"all_m1x1", rep(16'hFFFF), rep(16'd1), -32};
    tbl[3] = '{"min_x_min", rep(16'h8000), rep(16'h8000), 64'sd34359738368};
    tbl[4] = '{"two_x_m3", rep(16'd2), rep(16'hFFFD), -192};
    big = rep(16'h7FFF);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_beats", longint'(out_beats), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);

    // latency: out_valid exactly three cycles after accept
    neuron = rep(16'd1); weight = rep(16'd2); in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    chk("lat_c1", longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_c2", longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_c3", longint'(out_valid), 1);
    chk("lat_data", $signed(out_data), 64);
    chk("lat_beats", longint'(out_beats), 1);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      beat(tbl[i].n, tbl[i].w, 1'b1, 1'b1);
      wait_result(tbl[i].name, tbl[i].exp, 1, 0);
    end

    // 4-beat vector with one bubble
    beat(big, big, 1'b1, 1'b0);
    beat(big, big, 1'b0, 1'b0);
    @(negedge clk);
    beat(big, big, 1'b0, 1'b0);
    beat(big, big, 1'b0, 1'b1);
    wait_result("four_beat", 64'sd137430564992, 4, 0);

    // in_first mid-vector drops the prior partial sum
    beat(rep(16'd5), rep(16'd1), 1'b1, 1'b0);
    beat(rep(16'd1), rep(16'd1), 1'b1, 1'b1);
    wait_result("first_mid", 32, 1, 0);

    // back-pressure: result held, offered beat waits
    out_ready = 1'b0;
    beat(rep(16'd1), rep(16'd1), 1'b1, 1'b1);
    seen = 0;
    while (!out_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    neuron = rep(16'd1); weight = rep(16'd3); in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_data", $signed(out_data), 32);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    beat(rep(16'd2), rep(16'd2), 1'b1, 1'b1);
    wait_result("after_stall_b", 96, 1, 0);
    wait_result("after_stall_c", 128, 1, 0);

    // 32-bit accumulator overflow
    neuron = big; weight = big; in_first = 1'b1; in_last = 1'b1; v32 = 1'b1;
    @(negedge clk); v32 = 1'b0;
    seen = 0;
    while (!ov32 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("acc32_valid", longint'(ov32), 1);
`ifdef PE_DOT_ACC_SAT_EN
    chk("acc32_data", $signed(data32), 2147483647);
    chk("acc32_sat", longint'(sat32), 1);
`else
    chk("acc32_data", $signed(data32), -2097120);
    chk("acc32_sat", longint'(sat32), 0);
`endif
    chk("acc32_beats", longint'(beats32), 1);
    @(negedge clk);

    // reset after beat 2 of a 4-beat vector
    beat(rep(16'd1), rep(16'd1), 1'b1, 1'b0);
    beat(rep(16'd1), rep(16'd1), 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("rst_mid_no_valid", seen, 0);
    beat(rep(16'd1), rep(16'd1), 1'b0, 1'b1);
    wait_result("post_rst", 32, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
